consensus_persist_filter: RTL and testbench

- Parametrised, clocked successor to the 3-input all-equal (truth table 0x81) consensus gate.
- Evaluates an N_IN-bit input vector under a selectable consensus mode on each valid sample.
- Asserts its output only after consensus has held on the same value for a programmable number of consecutive valid samples.
- Sits between sensor/regulator input encoding and downstream circuit logic; acts as a glitch and persistence filter for consensus decisions.

---
 rtl/consensus_persist_filter_if.sv | 25 ++
 rtl/consensus_persist_filter.sv | 132 +++++++++++++
 tb/tb_consensus_persist_filter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/consensus_persist_filter_if.sv
// Sample/control bundle for consensus_persist_filter: input vector with mode and
// threshold controls, plus the registered consensus outputs.
interface consensus_persist_filter_if #(
    parameter int N_IN  = 3,
    parameter int CNT_W = 4
);
    logic             in_valid;
    logic [N_IN-1:0]  in_bus;
    logic [1:0]       mode;
    logic [CNT_W-1:0] hold_cycles;
    logic             out;
    logic             out_val;
    logic [CNT_W-1:0] run_cnt;
    logic             change_pulse;

    modport master (
        output in_valid, in_bus, mode, hold_cycles,
        input  out, out_val, run_cnt, change_pulse
    );

    modport slave (
        input  in_valid, in_bus, mode, hold_cycles,
        output out, out_val, run_cnt, change_pulse
    );
endinterface

// File: rtl/consensus_persist_filter.sv
// Clocked consensus gate with persistence: the flag asserts only after the same
// consensus value has held for a programmable number of consecutive valid samples.
module consensus_persist_filter #(
    parameter int N_IN  = 3,
    parameter int CNT_W = 4
) (
    input logic clk,
    input logic rst_n,
    consensus_persist_filter_if.slave cpf
);
    typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? CNT_MAX : v + CNT_ONE;
    endfunction

    state_t           state_p0, state_nx;
    logic             cand_p0, cand_nx;
    logic             out_p0, out_nx;
    logic             val_p0, val_nx;
    logic [CNT_W-1:0] cnt_p0, cnt_nx;
    logic             pulse_p0, pulse_nx;
    logic [1:0]       mode_p0;

    logic             match, c;
    logic [CNT_W-1:0] h_eff, cnt_inc;
    logic             h_one;
    int               ones;

    // Per-sample consensus evaluation
    always_comb begin
        ones  = 0;
        match = 1'b0;
        c     = 1'b0;
        for (int i = 0; i < N_IN; i++) ones = ones + int'(cpf.in_bus[i]);
        case (cpf.mode)
            2'b00: begin
                match = (cpf.in_bus == {N_IN{1'b0}}) || (cpf.in_bus == {N_IN{1'b1}});
                c     = cpf.in_bus[0];
            end
            2'b01: begin
                match = (cpf.in_bus == {N_IN{1'b1}});
                c     = 1'b1;
            end
            2'b10: begin
                match = (cpf.in_bus == {N_IN{1'b0}});
                c     = 1'b0;
            end
            default: begin
                // an even-width tie has no majority and therefore no consensus
                if (ones * 2 > N_IN) begin
                    match = 1'b1;
                    c     = 1'b1;
                end else if (ones * 2 < N_IN) begin
                    match = 1'b1;
                    c     = 1'b0;
                end
            end
        endcase
    end

    assign h_eff   = (cpf.hold_cycles == '0) ? CNT_ONE : cpf.hold_cycles;
    assign h_one   = (h_eff == CNT_ONE);
    assign cnt_inc = sat_inc(cnt_p0);

    always_comb begin
        state_nx = state_p0;
        cand_nx  = cand_p0;
        out_nx   = out_p0;
        val_nx   = val_p0;
        cnt_nx   = cnt_p0;
        if (cpf.mode != mode_p0) begin
            // a mode switch restarts the filter and discards the coincident sample
            state_nx = IDLE;
            cnt_nx   = '0;
            out_nx   = 1'b0;
        end else if (cpf.in_valid) begin
            if (!match) begin
                state_nx = IDLE;
                cnt_nx   = '0;
                out_nx   = 1'b0;
            end else if (state_p0 != IDLE && c == cand_p0) begin
                cnt_nx = cnt_inc;
                if (state_p0 == TRACK && cnt_inc >= h_eff) begin
                    state_nx = LOCKED;
                    out_nx   = 1'b1;
                    val_nx   = cand_p0;
                end
            end else begin
                cand_nx = c;
                cnt_nx  = CNT_ONE;
                if (h_one) begin
                    state_nx = LOCKED;
                    out_nx   = 1'b1;
                    val_nx   = c;
                end else begin
                    state_nx = TRACK;
                    out_nx   = 1'b0;
                end
            end
        end
        pulse_nx = (out_nx != out_p0) || (val_nx != val_p0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p0 <= IDLE;
            cand_p0  <= 1'b0;
            out_p0   <= 1'b0;
            val_p0   <= 1'b0;
            cnt_p0   <= '0;
            pulse_p0 <= 1'b0;
            mode_p0  <= cpf.mode;
        end else begin
            state_p0 <= state_nx;
            cand_p0  <= cand_nx;
            out_p0   <= out_nx;
            val_p0   <= val_nx;
            cnt_p0   <= cnt_nx;
            pulse_p0 <= pulse_nx;
            mode_p0  <= cpf.mode;
        end
    end

    assign cpf.out          = out_p0;
    assign cpf.out_val      = val_p0;
    assign cpf.run_cnt      = cnt_p0;
    assign cpf.change_pulse = pulse_p0;
endmodule

// File: tb/tb_consensus_persist_filter.sv
// Bench for consensus_persist_filter: two instances (N_IN=3/CNT_W=4 and N_IN=4/CNT_W=2)
// driven in lockstep and checked against a run-length reference model.
module tb_consensus_persist_filter;
    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    consensus_persist_filter_if #(.N_IN(3), .CNT_W(4)) if_a ();
    consensus_persist_filter_if #(.N_IN(4), .CNT_W(2)) if_b ();

    consensus_persist_filter #(.N_IN(3), .CNT_W(4)) dut_a (.clk(clk), .rst_n(rst_n), .cpf(if_a));
    consensus_persist_filter #(.N_IN(4), .CNT_W(2)) dut_b (.clk(clk), .rst_n(rst_n), .cpf(if_b));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: length of the current same-value consensus run plus a lock flag
    int         m_run    [2];
    bit         m_locked [2];
    bit         m_cand   [2];
    bit         m_val    [2];
    bit         m_pulse  [2];
    logic [1:0] m_mq     [2];

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset(input logic [1:0] md);
        for (int k = 0; k < 2; k++) begin
            m_run[k] = 0; m_locked[k] = 0; m_cand[k] = 0;
            m_val[k] = 0; m_pulse[k] = 0; m_mq[k] = md;
        end
    endfunction

    function automatic void model_step(input int k, input logic v, input logic [3:0] b,
                                       input logic [1:0] md, input logic [3:0] hd);
        int n, cmax, h, ones;
        bit match, c, same, pl, pv;
        n    = (k == 0) ? 3 : 4;
        cmax = (k == 0) ? 15 : 3;
        h    = (k == 0) ? int'(hd) : int'(hd[1:0]);
        if (h == 0) h = 1;
        pl = m_locked[k];
        pv = m_val[k];
        if (md != m_mq[k]) begin
            m_run[k] = 0; m_locked[k] = 0;
        end else if (v) begin
            ones = 0;
            for (int i = 0; i < n; i++) ones += int'(b[i]);
            match = 0; c = 0;
            case (md)
                2'b00: begin match = (ones == 0) || (ones == n); c = b[0]; end
                2'b01: begin match = (ones == n); c = 1; end
                2'b10: begin match = (ones == 0); c = 0; end
                default: begin
                    match = (2 * ones != n);
                    c = (2 * ones > n);
                end
            endcase
            if (!match) begin
                m_run[k] = 0; m_locked[k] = 0;
            end else begin
                same = (m_run[k] > 0) && (c == m_cand[k]);
                if (same) m_run[k] = (m_run[k] + 1 > cmax) ? cmax : m_run[k] + 1;
                else begin m_cand[k] = c; m_run[k] = 1; end
                m_locked[k] = (same && m_locked[k]) || (m_run[k] >= h);
                if (m_locked[k]) m_val[k] = m_cand[k];
            end
        end
        m_mq[k]    = md;
        m_pulse[k] = (m_locked[k] != pl) || (m_val[k] != pv);
    endfunction

    task automatic check_dut(input int k);
        if (k == 0) begin
            check_eq("a_out",   int'(if_a.out),          int'(m_locked[0]));
            check_eq("a_val",   int'(if_a.out_val),      int'(m_val[0]));
            check_eq("a_cnt",   int'(if_a.run_cnt),      m_run[0]);
            check_eq("a_pulse", int'(if_a.change_pulse), int'(m_pulse[0]));
        end else begin
            check_eq("b_out",   int'(if_b.out),          int'(m_locked[1]));
            check_eq("b_val",   int'(if_b.out_val),      int'(m_val[1]));
            check_eq("b_cnt",   int'(if_b.run_cnt),      m_run[1]);
            check_eq("b_pulse", int'(if_b.change_pulse), int'(m_pulse[1]));
        end
    endtask

    task automatic cycle(input logic v, input logic [3:0] b, input logic [1:0] md,
                         input logic [3:0] hd);
        if_a.in_valid = v; if_a.in_bus = b[2:0]; if_a.mode = md; if_a.hold_cycles = hd;
        if_b.in_valid = v; if_b.in_bus = b;      if_b.mode = md; if_b.hold_cycles = hd[1:0];
        @(posedge clk);
        model_step(0, v, b, md, hd);
        model_step(1, v, b, md, hd);
        #1;
        check_dut(0);
        check_dut(1);
    endtask

    initial begin
        logic [3:0] seq2 [6];
        int         cnt2 [6];
        logic [1:0] md;
        logic [3:0] hd, b;
        int         r;

        rst_n = 1'b0;
        if_a.in_valid = 0; if_a.in_bus = '0; if_a.mode = 2'b00; if_a.hold_cycles = '0;
        if_b.in_valid = 0; if_b.in_bus = '0; if_b.mode = 2'b00; if_b.hold_cycles = '0;
        model_reset(2'b00);
        #12;
        check_dut(0);
        check_dut(1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // all-equal, H=1: 000 locks on 0, 001 drops, 111 locks on 1
        cycle(1, 4'b0000, 2'b00, 4'd1);
        check_eq("tp1_out0", int'(if_a.out), 1);
        check_eq("tp1_val0", int'(if_a.out_val), 0);
        cycle(1, 4'b0001, 2'b00, 4'd1);
        check_eq("tp1_out1", int'(if_a.out), 0);
        cycle(1, 4'b0111, 2'b00, 4'd1);
        check_eq("tp1_out2", int'(if_a.out), 1);
        check_eq("tp1_val2", int'(if_a.out_val), 1);
        check_eq("tp1_pulse2", int'(if_a.change_pulse), 1);

        // all-equal, H=3, with an interrupting non-match
        cycle(1, 4'b0010, 2'b00, 4'd3);
        seq2 = '{4'b0111, 4'b0111, 4'b0011, 4'b0111, 4'b0111, 4'b0111};
        cnt2 = '{1, 2, 0, 1, 2, 3};
        for (int i = 0; i < 6; i++) begin
            cycle(1, seq2[i], 2'b00, 4'd3);
            check_eq("tp2_cnt", int'(if_a.run_cnt), cnt2[i]);
            check_eq("tp2_out", int'(if_a.out), (i == 5) ? 1 : 0);
        end

        // mode change while locked, no sample
        cycle(0, 4'b0000, 2'b01, 4'd3);
        check_eq("tp5_out", int'(if_a.out), 0);
        check_eq("tp5_cnt", int'(if_a.run_cnt), 0);
        check_eq("tp5_pulse", int'(if_a.change_pulse), 1);

        // asynchronous reset mid-track
        cycle(1, 4'b0111, 2'b01, 4'd5);
        cycle(1, 4'b0111, 2'b01, 4'd5);
        check_eq("tp7_pre_cnt", int'(if_a.run_cnt), 2);
        #3 rst_n = 1'b0;
        #1;
        check_eq("tp7_out", int'(if_a.out), 0);
        check_eq("tp7_cnt", int'(if_a.run_cnt), 0);
        check_eq("tp7_val", int'(if_a.out_val), 0);
        model_reset(2'b01);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // saturation of the 2-bit counter with H=1
        for (int i = 0; i < 6; i++) cycle(1, 4'b1111, 2'b01, 4'd1);
        check_eq("tp6_cnt", int'(if_b.run_cnt), 3);
        check_eq("tp6_out", int'(if_b.out), 1);

        // majority on 4 channels: tie, lock on 1, re-lock on 0
        cycle(0, 4'b0000, 2'b11, 4'd1);
        cycle(1, 4'b1100, 2'b11, 4'd1);
        check_eq("tp4_tie_out", int'(if_b.out), 0);
        check_eq("tp4_tie_cnt", int'(if_b.run_cnt), 0);
        cycle(1, 4'b1110, 2'b11, 4'd1);
        check_eq("tp4_out1", int'(if_b.out), 1);
        check_eq("tp4_val1", int'(if_b.out_val), 1);
        cycle(1, 4'b0001, 2'b11, 4'd1);
        check_eq("tp4_out2", int'(if_b.out), 1);
        check_eq("tp4_val2", int'(if_b.out_val), 0);
        check_eq("tp4_pulse2", int'(if_b.change_pulse), 1);

        // randomized traffic biased towards consensus runs
        md = 2'b11;
        hd = 4'd2;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 24) == 0) md = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0)  hd = 4'($urandom_range(0, 5));
            r = $urandom_range(0, 4);
            case (r)
                0:       b = 4'b0000;
                1:       b = 4'b1111;
                2:       b = 4'b0111;
                default: b = 4'($urandom);
            endcase
            cycle(($urandom_range(0, 3) != 0), b, md, hd);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete within 200000 time units");
        $fatal(1);
    end
endmodule
